mux_n_reg: RTL and testbench
============================

# mux_n_reg

Parametrised N-channel, W-bit registered multiplexer with per-channel valid, downstream valid/ready handshake and optional round-robin channel selection. Generalises the datapath 2:1 selectors of the multi-cycle CPU. Sits between multiple producers (register file read ports, ALU result, memory data, PC sources) and a single consumer stage that may stall. Holds the selected word stable for as many cycles as the consumer needs.

## Interface
Parameters:
- W, 32, data width per channel (>=1)
- N, 4, channel count (>=1)
- SW, derived localparam = max(1, clog2(N)), select/index width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- iC  in  N*W  channel data; channel k at bits [k*W +: W]
- iV  in  N  per-channel valid
- iS  in  SW  explicit channel select
- iMode  in  1  0 = explicit select, 1 = round-robin (see Configuration)
- oAck  out  N  one-hot; channel k consumed this cycle (combinational)
- oZ  out  W  registered selected data
- oCh  out  SW  index of channel held in oZ
- oV  out  1  oZ valid
- iRdy  in  1  consumer ready

## Operation
- Reset (rst high at a clock edge): oZ=0, oCh=0, oV=0, round-robin pointer ptr=N-1. While rst is high, oAck=0.
- Slot free: free = !oV || iRdy.
- Explicit mode (iMode=0): candidate c = iS. Grant when free && iS<N && iV[iS].
- Round-robin mode (iMode=1): search channels ptr+1, ptr+2, … wrapping modulo N; the first with iV set is the candidate. Grant when free and any iV set.
- On grant: oAck[c]=1; next edge oZ<=iC[c], oCh<=c, oV<=1. In RR mode ptr<=c. Otherwise ptr is unchanged.
- free with no grant: next edge oV<=0. oZ and oCh hold their last values.
- !free (oV && !iRdy): oZ, oCh and oV hold; oAck=0.
- iS>=N (N not a power of 2): treated as no valid input, no grant.
- N=1: iS and iMode are ignored; channel 0 is always the candidate.
- iMode may change on any cycle and is sampled combinationally. ptr survives mode changes.

## Timing
- Latency: 1 cycle from grant (oAck) to oV/oZ.
- Throughput: 1 word/cycle when iRdy is held high.
- oAck depends combinationally on iV, iS, iMode, iRdy, oV and ptr. There is no combinational path from iC to any output.
- Simultaneous iRdy && grant: the held word is retired and the new word loads on the same edge with no bubble.
- Reset mid-transfer: the held word is dropped, and oV=0 on the cycle after the reset edge.

## Configuration
- ROUND_ROBIN_EN defined: round-robin arbiter and ptr are compiled in; iMode selects the mode.
- Not defined: iMode is present but ignored, operation is explicit-select only, and no ptr register exists. Port list is identical in both builds.

## Structure
- Shared package: mode constants MODE_SEL=1'b0 and MODE_RR=1'b1, plus a clog2 function for SW.
- One sub-module, rr_arb_n (parameter N): holds ptr and produces the one-hot grant and grant index from a request vector and an update strobe. Instantiated only under ROUND_ROBIN_EN.

## Test plan
- Reset: hold rst 2 cycles with all iV=1 -> oV=0, oZ=0, oCh=0, oAck=0 throughout; first grant after release goes to channel 0 in RR mode.
- Explicit select, W=32, N=4: iC2=32'hDEADBEEF, iV=4'b0100, iS=2, iRdy=1 -> oAck=4'b0100, then the next cycle oZ=32'hDEADBEEF, oCh=2, oV=1.
- Stall: oV=1 with iRdy=0 for 3 cycles while iC changes -> oZ stable, oAck=0; iRdy=1 on cycle 4 with a new grant -> new word loads with no bubble.
- Round-robin: iMode=1, iV=4'b1111 held with iRdy=1 -> oCh sequence 0,1,2,3,0; then iV=4'b1010 -> alternates 1,3.
- Invalid select, N=3: iS=3 with iV=3'b111 -> no oAck, oV drops to 0 after the held word retires.
- Reset mid-transfer: oV=1 with iRdy=0, assert rst for 1 cycle -> oV=0 on the next cycle and ptr reinitialised (next RR grant is channel 0).

Source files
------------

// File: rtl/mux_n_reg_pkg.sv
// Shared constants for the registered N-way multiplexer: mode encodings and index-width helper.
package mux_n_reg_pkg;

   localparam logic MODE_SEL = 1'b0;
   localparam logic MODE_RR  = 1'b1;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/mux_n_reg_rr_arb.sv
// Round-robin arbiter: searches from ptr+1 upward (mod N) for the first request; ptr moves to the grantee on upd.
module rr_arb_n
   import mux_n_reg_pkg::*;
#(
   parameter  int N  = 4,
   localparam int SW = (N > 1) ? clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req,
   input  logic          upd,
   output logic [N-1:0]  gnt,
   output logic [SW-1:0] gnt_idx,
   output logic          any
);

   logic [SW-1:0] ptr;

   always_comb begin
      int idx;
      idx     = 0;
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      for (int i = 1; i <= N; i++) begin
         idx = (int'(ptr) + i) % N;
         if (!any && req[idx]) begin
            any      = 1'b1;
            gnt[idx] = 1'b1;
            gnt_idx  = SW'(idx);
         end
      end
   end

   // Starting at N-1 makes channel 0 the first winner after reset.
   always_ff @(posedge clk) begin
      if (rst)
         ptr <= SW'(N - 1);
      else if (upd)
         ptr <= gnt_idx;
   end

endmodule

// File: rtl/mux_n_reg.sv
// N-channel W-bit registered mux with valid/ready output; round-robin selection compiled in under ROUND_ROBIN_EN.
// Latency 1 cycle grant->oZ; oZ/oCh/oV hold while oV && !iRdy, and a new word loads on the retiring edge.
module mux_n_reg
   import mux_n_reg_pkg::*;
#(
   parameter  int W  = 32,
   parameter  int N  = 4,
   localparam int SW = (N > 1) ? clog2(N) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N*W-1:0]  iC,
   input  logic [N-1:0]    iV,
   input  logic [SW-1:0]   iS,
   input  logic            iMode,
   output logic [N-1:0]    oAck,
   output logic [W-1:0]    oZ,
   output logic [SW-1:0]   oCh,
   output logic            oV,
   input  logic            iRdy
);

   logic          free;
   logic          grant;
   logic          sel_req;
   logic [SW-1:0] sel_idx;
   logic [N-1:0]  sel_oh;
   logic [SW-1:0] cand;
   logic [N-1:0]  ack_src;

   assign free = !oV || iRdy;

   // Out-of-range selects never match any k, so they simply request nothing.
   always_comb begin
      sel_req = 1'b0;
      sel_idx = '0;
      sel_oh  = '0;
      if (N == 1) begin
         sel_req   = iV[0];
         sel_oh[0] = 1'b1;
      end else begin
         for (int k = 0; k < N; k++) begin
            if (iS == SW'(k)) begin
               sel_req   = iV[k];
               sel_idx   = SW'(k);
               sel_oh[k] = 1'b1;
            end
         end
      end
   end

`ifdef ROUND_ROBIN_EN
   logic          rr_mode;
   logic          rr_any;
   logic [N-1:0]  rr_gnt;
   logic [SW-1:0] rr_idx;

   assign rr_mode = (iMode == MODE_RR);

   rr_arb_n #(.N(N)) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (iV),
      .upd     (grant && rr_mode),
      .gnt     (rr_gnt),
      .gnt_idx (rr_idx),
      .any     (rr_any)
   );

   assign cand    = rr_mode ? rr_idx : sel_idx;
   assign ack_src = rr_mode ? rr_gnt : sel_oh;
   assign grant   = !rst && free && (rr_mode ? rr_any : sel_req);
`else
   logic unused_mode;
   assign unused_mode = iMode;
   assign cand        = sel_idx;
   assign ack_src     = sel_oh;
   assign grant       = !rst && free && sel_req;
`endif

   assign oAck = grant ? ack_src : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         oZ  <= '0;
         oCh <= '0;
         oV  <= 1'b0;
      end else if (free) begin
         oV <= grant;
         if (grant) begin
            oZ  <= iC[int'(cand)*W +: W];
            oCh <= cand;
         end
      end
   end

endmodule

// File: tb/tb_mux_n_reg.sv
// Directed test of mux_n_reg: a W=32/N=4 instance and a W=8/N=3 instance for the invalid-select case.
module tb_mux_n_reg;
   import mux_n_reg_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // N=4, W=32 instance
   logic [127:0] c4;
   logic [3:0]   v4;
   logic [1:0]   s4;
   logic         m4;
   logic [3:0]   ack4;
   logic [31:0]  z4;
   logic [1:0]   ch4;
   logic         ov4;
   logic         rdy4;

   // N=3, W=8 instance
   logic [23:0]  c3;
   logic [2:0]   v3;
   logic [1:0]   s3;
   logic         m3;
   logic [2:0]   ack3;
   logic [7:0]   z3;
   logic [1:0]   ch3;
   logic         ov3;
   logic         rdy3;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] d4 [4];

   mux_n_reg #(.W(32), .N(4)) u4 (
      .clk(clk), .rst(rst), .iC(c4), .iV(v4), .iS(s4), .iMode(m4),
      .oAck(ack4), .oZ(z4), .oCh(ch4), .oV(ov4), .iRdy(rdy4)
   );

   mux_n_reg #(.W(8), .N(3)) u3 (
      .clk(clk), .rst(rst), .iC(c3), .iV(v3), .iS(s3), .iMode(m3),
      .oAck(ack3), .oZ(z3), .oCh(ch3), .oV(ov3), .iRdy(rdy3)
   );

   // Inputs change 1 time unit after the rising edge; outputs are read there too.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      v4 = 4'b1111; v3 = 3'b111; m4 = MODE_RR; m3 = MODE_RR;
      rdy4 = 1'b1; rdy3 = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         n_checks++; if (ov4 !== 1'b0) begin n_errors++; $display("FAIL reset_ov4 cyc%0d: got %b want 0", i, ov4); end
         n_checks++; if (z4 !== 32'h0) begin n_errors++; $display("FAIL reset_z4 cyc%0d: got %h want 0", i, z4); end
         n_checks++; if (ch4 !== 2'd0) begin n_errors++; $display("FAIL reset_ch4 cyc%0d: got %0d want 0", i, ch4); end
         n_checks++; if (ack4 !== 4'b0000) begin n_errors++; $display("FAIL reset_ack4 cyc%0d: got %b want 0000", i, ack4); end
         n_checks++; if (ack3 !== 3'b000) begin n_errors++; $display("FAIL reset_ack3 cyc%0d: got %b want 000", i, ack3); end
         n_checks++; if (ov3 !== 1'b0) begin n_errors++; $display("FAIL reset_ov3 cyc%0d: got %b want 0", i, ov3); end
      end
      v4 = 4'b0000; v3 = 3'b000; m4 = MODE_SEL; m3 = MODE_SEL;
      rst = 1'b0;
      step();
   endtask

   task automatic test_explicit();
      m4 = MODE_SEL; s4 = 2'd1; v4 = 4'b0100; rdy4 = 1'b1;
      #1;
      n_checks++; if (ack4 !== 4'b0000) begin n_errors++; $display("FAIL expl_unsel_ack: got %b want 0000", ack4); end
      s4 = 2'd2;
      #1;
      n_checks++; if (ack4 !== 4'b0100) begin n_errors++; $display("FAIL expl_ack: got %b want 0100", ack4); end
      step();
      n_checks++; if (z4 !== 32'hDEADBEEF) begin n_errors++; $display("FAIL expl_z: got %h want deadbeef", z4); end
      n_checks++; if (ch4 !== 2'd2) begin n_errors++; $display("FAIL expl_ch: got %0d want 2", ch4); end
      n_checks++; if (ov4 !== 1'b1) begin n_errors++; $display("FAIL expl_ov: got %b want 1", ov4); end
      v4 = 4'b0000;
      step();
      n_checks++; if (ov4 !== 1'b0) begin n_errors++; $display("FAIL expl_drop_ov: got %b want 0", ov4); end
      n_checks++; if (z4 !== 32'hDEADBEEF) begin n_errors++; $display("FAIL expl_hold_z: got %h want deadbeef", z4); end
      n_checks++; if (ch4 !== 2'd2) begin n_errors++; $display("FAIL expl_hold_ch: got %0d want 2", ch4); end
   endtask

   task automatic test_mode_ignored();
      m4 = MODE_RR; s4 = 2'd1; v4 = 4'b1111; rdy4 = 1'b1;
      #1;
      n_checks++; if (ack4 !== 4'b0010) begin n_errors++; $display("FAIL mode_ign_ack: got %b want 0010", ack4); end
      step();
      n_checks++; if (ch4 !== 2'd1) begin n_errors++; $display("FAIL mode_ign_ch: got %0d want 1", ch4); end
      v4 = 4'b0000; m4 = MODE_SEL;
      step();
   endtask

   task automatic test_stall();
      m4 = MODE_SEL; s4 = 2'd0; v4 = 4'b0001; rdy4 = 1'b1;
      step();
      n_checks++; if (z4 !== 32'h1111_1111) begin n_errors++; $display("FAIL stall_load_z: got %h want 11111111", z4); end
      rdy4 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         c4[31:0] = 32'hBAD0_0000 + 32'(i);
         #1;
         n_checks++; if (ack4 !== 4'b0000) begin n_errors++; $display("FAIL stall_ack cyc%0d: got %b want 0000", i, ack4); end
         step();
         n_checks++; if (z4 !== 32'h1111_1111) begin n_errors++; $display("FAIL stall_z cyc%0d: got %h want 11111111", i, z4); end
         n_checks++; if (ov4 !== 1'b1) begin n_errors++; $display("FAIL stall_ov cyc%0d: got %b want 1", i, ov4); end
      end
      rdy4 = 1'b1; s4 = 2'd1; v4 = 4'b0010; c4[63:32] = 32'hAAAA_0001;
      #1;
      n_checks++; if (ack4 !== 4'b0010) begin n_errors++; $display("FAIL stall_release_ack: got %b want 0010", ack4); end
      step();
      n_checks++; if (z4 !== 32'hAAAA_0001) begin n_errors++; $display("FAIL stall_nobubble_z: got %h want aaaa0001", z4); end
      n_checks++; if (ch4 !== 2'd1) begin n_errors++; $display("FAIL stall_nobubble_ch: got %0d want 1", ch4); end
      n_checks++; if (ov4 !== 1'b1) begin n_errors++; $display("FAIL stall_nobubble_ov: got %b want 1", ov4); end
      v4 = 4'b0000;
      c4 = {d4[3], d4[2], d4[1], d4[0]};
      step();
   endtask

   task automatic test_round_robin();
      int seq_a [5];
      int seq_b [3];
      seq_a = '{0, 1, 2, 3, 0};
      seq_b = '{1, 3, 1};
      m4 = MODE_RR; v4 = 4'b1111; rdy4 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_checks++; if (ack4 !== 4'(1 << seq_a[i])) begin n_errors++; $display("FAIL rr_all_ack %0d: got %b want ch%0d", i, ack4, seq_a[i]); end
         step();
         n_checks++; if (ch4 !== 2'(seq_a[i])) begin n_errors++; $display("FAIL rr_all_ch %0d: got %0d want %0d", i, ch4, seq_a[i]); end
         n_checks++; if (z4 !== d4[seq_a[i]]) begin n_errors++; $display("FAIL rr_all_z %0d: got %h want %h", i, z4, d4[seq_a[i]]); end
      end
      v4 = 4'b1010;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++; if (ch4 !== 2'(seq_b[i])) begin n_errors++; $display("FAIL rr_alt_ch %0d: got %0d want %0d", i, ch4, seq_b[i]); end
         n_checks++; if (ov4 !== 1'b1) begin n_errors++; $display("FAIL rr_alt_ov %0d: got %b want 1", i, ov4); end
      end
      v4 = 4'b0000; m4 = MODE_SEL;
      step();
   endtask

   task automatic test_invalid_sel();
      c3 = {8'h33, 8'h22, 8'h11};
      m3 = MODE_SEL; s3 = 2'd0; v3 = 3'b111; rdy3 = 1'b1;
      step();
      n_checks++; if (z3 !== 8'h11) begin n_errors++; $display("FAIL inv_load_z: got %h want 11", z3); end
      s3 = 2'd3;
      #1;
      n_checks++; if (ack3 !== 3'b000) begin n_errors++; $display("FAIL inv_ack: got %b want 000", ack3); end
      step();
      n_checks++; if (ov3 !== 1'b0) begin n_errors++; $display("FAIL inv_ov: got %b want 0", ov3); end
      n_checks++; if (z3 !== 8'h11) begin n_errors++; $display("FAIL inv_hold_z: got %h want 11", z3); end
      s3 = 2'd2;
      #1;
      n_checks++; if (ack3 !== 3'b100) begin n_errors++; $display("FAIL inv_edge_ack: got %b want 100", ack3); end
      step();
      n_checks++; if (z3 !== 8'h33) begin n_errors++; $display("FAIL inv_edge_z: got %h want 33", z3); end
      v3 = 3'b000;
      step();
   endtask

   task automatic test_reset_mid();
      m4 = MODE_SEL; s4 = 2'd3; v4 = 4'b1000; rdy4 = 1'b1;
      step();
      v4 = 4'b0000; rdy4 = 1'b0;
      step();
      n_checks++; if (ov4 !== 1'b1) begin n_errors++; $display("FAIL mid_pre_ov: got %b want 1", ov4); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_checks++; if (ov4 !== 1'b0) begin n_errors++; $display("FAIL mid_ov: got %b want 0", ov4); end
      n_checks++; if (z4 !== 32'h0) begin n_errors++; $display("FAIL mid_z: got %h want 0", z4); end
`ifdef ROUND_ROBIN_EN
      m4 = MODE_RR; v4 = 4'b1111; rdy4 = 1'b1;
      #1;
      n_checks++; if (ack4 !== 4'b0001) begin n_errors++; $display("FAIL mid_rr_ack: got %b want 0001", ack4); end
      step();
      n_checks++; if (ch4 !== 2'd0) begin n_errors++; $display("FAIL mid_rr_ch: got %0d want 0", ch4); end
`else
      rdy4 = 1'b1; s4 = 2'd0; v4 = 4'b0001;
      step();
      n_checks++; if (ch4 !== 2'd0 || ov4 !== 1'b1) begin n_errors++; $display("FAIL mid_reload: got ch%0d v%b want ch0 v1", ch4, ov4); end
`endif
      v4 = 4'b0000;
      step();
   endtask

   initial begin
      d4[0] = 32'h1111_1111;
      d4[1] = 32'h2222_2222;
      d4[2] = 32'hDEADBEEF;
      d4[3] = 32'h4444_4444;
      c4 = {d4[3], d4[2], d4[1], d4[0]};
      c3 = '0; s3 = '0; s4 = '0;
      m3 = MODE_SEL; m4 = MODE_SEL;
      v3 = '0; v4 = '0; rdy3 = 1'b1; rdy4 = 1'b1;
      rst = 1'b1;
      #1;
      test_reset();
      test_explicit();
      test_stall();
`ifdef ROUND_ROBIN_EN
      test_round_robin();
`else
      test_mode_ignored();
`endif
      test_invalid_sel();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
